// File: rtl/csr_pkg.sv
// ----------------------------------------------------------------------------
// csr_pkg : shared Zicsr encodings, CSR addresses and FSM states
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package csr_pkg;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  localparam logic [1:0] RO_SPACE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_state_e;

endpackage

`default_nettype wire

// File: rtl/csr_access_unit_if.sv
// ----------------------------------------------------------------------------
// csr_access_unit_if : pipeline request/response bus of the CSR access unit
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface csr_access_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
);

  logic              req_valid_i;
  logic              req_ready_o;
  logic [2:0]        funct3_i;
  logic [ADDR_W-1:0] csr_addr_i;
  logic [XLEN-1:0]   rs1_data_i;
  logic [4:0]        rs1_idx_i;
  logic [4:0]        rd_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [XLEN-1:0]   resp_data_o;
  logic [4:0]        resp_rd_o;
  logic              resp_illegal_o;

  // Port suffixes are named from the unit's point of view.
  modport slave (
    input  req_valid_i, funct3_i, csr_addr_i, rs1_data_i, rs1_idx_i, rd_i,
    input  resp_ready_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_rd_o, resp_illegal_o
  );

  modport master (
    output req_valid_i, funct3_i, csr_addr_i, rs1_data_i, rs1_idx_i, rd_i,
    output resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_rd_o, resp_illegal_o
  );

endinterface

`default_nettype wire

// File: rtl/csr_alu.sv
// ----------------------------------------------------------------------------
// csr_alu : new-value, write-enable and illegal-access computation
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  wire logic [2:0]        funct3_i,
  input  wire logic [XLEN-1:0]   old_i,
  input  wire logic [XLEN-1:0]   operand_i,
  input  wire logic [4:0]        rs1_idx_i,
  input  wire logic [ADDR_W-1:0] addr_i,
  output logic      [XLEN-1:0]   new_o,
  output logic                   we_o,
  output logic                   illegal_o
);

  logic bad_funct3;

  always_comb begin
    new_o      = old_i;
    we_o       = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3_i)
      CSRRW, CSRRWI: begin
        new_o = operand_i;
        we_o  = 1'b1;
      end
      // Set/clear forms only write when a source register is named,
      // regardless of whether its value happens to be zero.
      CSRRS, CSRRSI: begin
        new_o = old_i | operand_i;
        we_o  = (rs1_idx_i != 5'd0);
      end
      CSRRC, CSRRCI: begin
        new_o = old_i & ~operand_i;
        we_o  = (rs1_idx_i != 5'd0);
      end
      default: bad_funct3 = 1'b1;
    endcase
    illegal_o = bad_funct3 | (we_o & (addr_i[ADDR_W-1 -: 2] == RO_SPACE));
  end

endmodule

`default_nettype wire

// File: rtl/csr_access_unit.sv
// ----------------------------------------------------------------------------
// csr_access_unit : execute-stage Zicsr initiator (read, modify, write back)
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module csr_access_unit
  import csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  wire logic              clk_i,
  input  wire logic              reset_i,
  csr_access_unit_if.slave       pipe,
  output logic      [ADDR_W-1:0] csrRaddr_o,
  input  wire logic [XLEN-1:0]   csrRData_i,
  output logic      [ADDR_W-1:0] csrWaddr_o,
  output logic      [XLEN-1:0]   csrWData_o,
  output logic                   csrWe_o
);

  csr_state_e        state_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   operand_q;
  logic [4:0]        rs1_idx_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   old_q;

  logic              req_ready_q;
  logic              resp_valid_q;
  logic [XLEN-1:0]   resp_data_q;
  logic [4:0]        resp_rd_q;
  logic              resp_illegal_q;
  logic [ADDR_W-1:0] csr_raddr_q;
  logic [ADDR_W-1:0] csr_waddr_q;
  logic [XLEN-1:0]   csr_wdata_q;
  logic              csr_we_q;

  logic [XLEN-1:0]   new_d;
  logic              we_d;
  logic              illegal_d;

  csr_alu #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_alu (
    .funct3_i  (funct3_q),
    .old_i     (csrRData_i),
    .operand_i (operand_q),
    .rs1_idx_i (rs1_idx_q),
    .addr_i    (addr_q),
    .new_o     (new_d),
    .we_o      (we_d),
    .illegal_o (illegal_d)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      funct3_q       <= '0;
      addr_q         <= '0;
      operand_q      <= '0;
      rs1_idx_q      <= '0;
      rd_q           <= '0;
      old_q          <= '0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_rd_q      <= '0;
      resp_illegal_q <= 1'b0;
      csr_raddr_q    <= '0;
      csr_waddr_q    <= '0;
      csr_wdata_q    <= '0;
      csr_we_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pipe.req_valid_i && req_ready_q) begin
            funct3_q    <= pipe.funct3_i;
            addr_q      <= pipe.csr_addr_i;
            // Immediate forms carry the uimm in the rs1 field.
            operand_q   <= pipe.funct3_i[2] ? {{(XLEN-5){1'b0}}, pipe.rs1_idx_i}
                                            : pipe.rs1_data_i;
            rs1_idx_q   <= pipe.rs1_idx_i;
            rd_q        <= pipe.rd_i;
            csr_raddr_q <= pipe.csr_addr_i;
            req_ready_q <= 1'b0;
            state_q     <= ST_READ;
          end
        end

        ST_READ: begin
          old_q       <= csrRData_i;
          csr_raddr_q <= '0;
          if (illegal_d || !we_d) begin
            resp_valid_q   <= 1'b1;
            resp_data_q    <= illegal_d ? '0 : csrRData_i;
            resp_rd_q      <= rd_q;
            resp_illegal_q <= illegal_d;
            state_q        <= ST_RESP;
          end else begin
            csr_we_q    <= 1'b1;
            csr_waddr_q <= addr_q;
            csr_wdata_q <= new_d;
            state_q     <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          csr_we_q       <= 1'b0;
          csr_waddr_q    <= '0;
          csr_wdata_q    <= '0;
          resp_valid_q   <= 1'b1;
          resp_data_q    <= old_q;
          resp_rd_q      <= rd_q;
          resp_illegal_q <= 1'b0;
          state_q        <= ST_RESP;
        end

        ST_RESP: begin
          if (pipe.resp_ready_i) begin
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_rd_q      <= '0;
            resp_illegal_q <= 1'b0;
            req_ready_q    <= 1'b1;
            state_q        <= ST_IDLE;
          end
        end

        default: begin
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign pipe.req_ready_o    = req_ready_q;
  assign pipe.resp_valid_o   = resp_valid_q;
  assign pipe.resp_data_o    = resp_data_q;
  assign pipe.resp_rd_o      = resp_rd_q;
  assign pipe.resp_illegal_o = resp_illegal_q;
  assign csrRaddr_o          = csr_raddr_q;
  assign csrWaddr_o          = csr_waddr_q;
  assign csrWData_o          = csr_wdata_q;
  assign csrWe_o             = csr_we_q;

endmodule

`default_nettype wire

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the CSR register-file interface; sits in the execute stage.
- Accepts one decoded Zicsr instruction at a time from the pipeline, reads the addressed CSR and computes the new value.
- Issues the write-back to the CSR register file, then returns the old CSR value for rd.
- Flags illegal accesses: writes to read-only CSRs and unknown funct3 encodings.

Parameters:
- XLEN, 32, data width of CSR values and rs1 operand
- ADDR_W, 12, CSR address width

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  pipeline presents a CSR instruction
- req_ready_o  out  1  unit can accept a request (high only in IDLE)
- funct3_i  in  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
- csr_addr_i  in  ADDR_W  CSR address (imm[11:0])
- rs1_data_i  in  XLEN  rs1 register value
- rs1_idx_i  in  5  rs1 index; also the uimm for the immediate forms
- rd_i  in  5  destination register index
- resp_valid_o  out  1  result available
- resp_ready_i  in  1  pipeline consumes result
- resp_data_o  out  XLEN  old CSR value for rd
- resp_rd_o  out  5  destination index
- resp_illegal_o  out  1  illegal-instruction flag, qualified by resp_valid_o
- csrRaddr_o  out  ADDR_W  CSR read address
- csrRData_i  in  XLEN  CSR read data (combinational from register file)
- csrWaddr_o  out  ADDR_W  CSR write address
- csrWData_o  out  XLEN  CSR write data
- csrWe_o  out  1  CSR write strobe, one cycle

Behaviour:
- Reset (async, active-high): state=IDLE.
  - All outputs 0, except req_ready_o=1.
  - Any latched request is discarded and no write is issued, including when reset arrives mid-operation.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - Accept when req_valid_i & req_ready_o.
  - Latch funct3, addr, operand, rd and rs1_idx, then go to READ.
- Operand selection: funct3[2]=1 gives zero-extended rs1_idx_i (uimm); otherwise rs1_data_i.
- READ (1 cycle):
  - csrRaddr_o = latched addr; capture csrRData_i as old.
  - RW: new = operand. RS: new = old | operand. RC: new = old & ~operand.
- Write enable:
  - RW/RWI always write.
  - RS/RC/RSI/RCI write only when rs1_idx != 0. The rs1 index is the criterion, not the operand value.
- Illegal when either holds:
  - funct3 is one of 000 or 100;
  - the write enable is set and addr[11:10]==2'b11 (read-only space).
- READ exit: if illegal or no write, go to RESP; otherwise go to WRITE.
- WRITE (1 cycle): csrWe_o=1, csrWaddr_o=addr, csrWData_o=new; then go to RESP.
  - csrWe_o is never high in any other state.
  - Illegal requests never write.
- RESP:
  - resp_valid_o=1 with resp_data_o=old, resp_rd_o=rd, resp_illegal_o set as computed.
  - If illegal, resp_data_o=0.
  - Hold all outputs stable until resp_ready_i; on that cycle return to IDLE.
  - Back-to-back requests have one IDLE cycle between them.
- Latency from accept to resp_valid_o: 2 cycles without a write, 3 cycles with a write.
- Counters such as cycle keep advancing while a request is in flight. The value read is the READ-cycle value; a write lands in the WRITE cycle.
- rd=0 is still reported; suppressing the rd write is the pipeline's job.

Decomposition:
- Shared package csr_pkg:
  - funct3 localparams (CSRRW..CSRRCI);
  - CSR address constants (CYCLE 0xC00, CYCLEH 0xC80, INSTRET 0xC02, INSTRETH 0xC82);
  - FSM state encoding;
  - RO_SPACE = 2'b11.
- One sub-module, csr_alu: combinational new-value / write-enable / illegal computation from (funct3, old, operand, rs1_idx, addr).

Test Plan:
- CSRRS rd=5, rs1_idx=0, addr 0xC00, cycle=100 at READ -> resp_data_o=100 two cycles after accept, csrWe_o never asserted, illegal=0.
- CSRRW addr 0x340, rs1_data=0xDEADBEEF, old=0x12 -> csrWe_o one cycle, csrWData_o=0xDEADBEEF, csrWaddr_o=0x340, resp_data_o=0x12 three cycles after accept.
- CSRRCI addr 0x300, uimm=0x5, old=0xF -> csrWData_o=0xA, resp_data_o=0xF.
- CSRRW addr 0xC02 (read-only) -> no csrWe_o, resp_illegal_o=1, resp_data_o=0; also funct3=100 -> illegal.
- resp_ready_i held low 4 cycles in RESP -> outputs stable, req_ready_o=0; a second request with req_valid_i high is accepted only after the IDLE return.
- reset_i asserted asynchronously during READ of a CSRRW -> req_ready_o=1 immediately, csrWe_o stays 0, resp_valid_o=0.
